// File: rtl/thermal_pkg.sv
// rtl/thermal_pkg.sv - shared types and encodings for the thermal plant model
package thermal_pkg;

  localparam int TEMP_W = 8;

  localparam logic [1:0] MODE_IDLE     = 2'd0;
  localparam logic [1:0] MODE_HEATING  = 2'd1;
  localparam logic [1:0] MODE_COOLING  = 2'd2;
  localparam logic [1:0] MODE_CONFLICT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = MODE_IDLE,
    ST_HEATING  = MODE_HEATING,
    ST_COOLING  = MODE_COOLING,
    ST_CONFLICT = MODE_CONFLICT
  } state_t;

  // Next state depends only on the sampled drives, never on the present state.
  function automatic state_t next_state(input logic heater, input logic cooler);
    case ({heater, cooler})
      2'b11:   return ST_CONFLICT;
      2'b10:   return ST_HEATING;
      2'b01:   return ST_COOLING;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/thermal_plant_if.sv
// rtl/thermal_plant_if.sv - controller <-> plant signal bundle
interface thermal_plant_if;
  import thermal_pkg::*;

  logic              heater_on;
  logic              cooler_on;
  logic [TEMP_W-1:0] ambient_temp;
  logic              temp_load;
  logic [TEMP_W-1:0] load_value;
  logic [TEMP_W-1:0] current_temp;
  logic              temp_valid;
  logic [1:0]        mode;
  logic              fault;

  modport master (
    output heater_on, cooler_on, ambient_temp, temp_load, load_value,
    input  current_temp, temp_valid, mode, fault
  );

  modport slave (
    input  heater_on, cooler_on, ambient_temp, temp_load, load_value,
    output current_temp, temp_valid, mode, fault
  );

endinterface

// File: rtl/thermal_step_timer.sv
// rtl/thermal_step_timer.sv - per-state step counter; idle drift counting under AMBIENT_DRIFT_EN
module thermal_step_timer
  import thermal_pkg::*;
#(
  parameter int HEAT_PERIOD  = 8,
  parameter int COOL_PERIOD  = 8,
  parameter int DRIFT_PERIOD = 32
) (
  input  logic   clk,
  input  logic   reset,
  input  state_t state_i,
  input  logic   clear_i,
  output logic   step_o
);

  localparam logic [TEMP_W-1:0] HEAT_LAST  = TEMP_W'(HEAT_PERIOD - 1);
  localparam logic [TEMP_W-1:0] COOL_LAST  = TEMP_W'(COOL_PERIOD - 1);
  localparam logic [TEMP_W-1:0] DRIFT_LAST = TEMP_W'(DRIFT_PERIOD - 1);

  logic [TEMP_W-1:0] cnt_q, cnt_d;
  logic [TEMP_W-1:0] last;
  logic              active;

  always_comb begin
    active = 1'b0;
    last   = '0;
    case (state_i)
      ST_HEATING: begin active = 1'b1; last = HEAT_LAST; end
      ST_COOLING: begin active = 1'b1; last = COOL_LAST; end
      ST_IDLE: begin
        last = DRIFT_LAST;
`ifdef AMBIENT_DRIFT_EN
        active = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  assign step_o = active && (cnt_q == last);

  // Inactive states pin the counter at zero so re-entry always needs a full period.
  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (clear_i || !active || step_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/thermal_plant.sv
// rtl/thermal_plant.sv - heater/cooler thermal model; AMBIENT_DRIFT_EN enables idle drift to ambient
module thermal_plant
  import thermal_pkg::*;
#(
  parameter int                HEAT_PERIOD  = 8,
  parameter int                COOL_PERIOD  = 8,
  parameter int                DRIFT_PERIOD = 32,
  parameter logic [TEMP_W-1:0] INIT_TEMP    = 8'd20
) (
  input logic            clk,
  input logic            reset,
  thermal_plant_if.slave bus
);

  state_t            state_q, state_d;
  logic [TEMP_W-1:0] temp_q, temp_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic              step;

  thermal_step_timer #(
    .HEAT_PERIOD (HEAT_PERIOD),
    .COOL_PERIOD (COOL_PERIOD),
    .DRIFT_PERIOD(DRIFT_PERIOD)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .state_i(state_q),
    .clear_i((state_d != state_q) || bus.temp_load),
    .step_o (step)
  );

`ifndef AMBIENT_DRIFT_EN
  logic unused_ambient;
  assign unused_ambient = ^bus.ambient_temp;
`endif

  always_comb begin
    state_d = next_state(bus.heater_on, bus.cooler_on);
    fault_d = fault_q || (state_d == ST_CONFLICT);
    temp_d  = temp_q;
    valid_d = 1'b0;
    // A load wins outright and swallows any step due in the same cycle.
    if (bus.temp_load) begin
      temp_d  = bus.load_value;
      valid_d = 1'b1;
    end else if (step) begin
      case (state_q)
        ST_HEATING: if (temp_q != 8'd255) begin temp_d = temp_q + 8'd1; valid_d = 1'b1; end
        ST_COOLING: if (temp_q != 8'd0)   begin temp_d = temp_q - 8'd1; valid_d = 1'b1; end
`ifdef AMBIENT_DRIFT_EN
        ST_IDLE: begin
          if (temp_q < bus.ambient_temp) begin temp_d = temp_q + 8'd1; valid_d = 1'b1; end
          else if (temp_q > bus.ambient_temp) begin temp_d = temp_q - 8'd1; valid_d = 1'b1; end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      temp_q  <= INIT_TEMP;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      temp_q  <= temp_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign bus.current_temp = temp_q;
  assign bus.temp_valid   = valid_q;
  assign bus.mode         = state_q;
  assign bus.fault        = fault_q;

endmodule

// File: tb/tb_thermal_plant.sv
// tb/tb_thermal_plant.sv - directed self-checking bench for thermal_plant (HEAT 4, COOL 6, DRIFT 4)
module tb_thermal_plant;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   pulses;

  thermal_plant_if bus ();

  thermal_plant #(
    .HEAT_PERIOD (4),
    .COOL_PERIOD (6),
    .DRIFT_PERIOD(4),
    .INIT_TEMP   (8'd20)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset            = 1'b1;
    bus.heater_on    = 1'b0;
    bus.cooler_on    = 1'b0;
    bus.ambient_temp = 8'd27;
    bus.temp_load    = 1'b0;
    bus.load_value   = 8'd0;
    tick(2);
    chk("rst_temp",  bus.current_temp, 20);
    chk("rst_mode",  bus.mode, 0);
    chk("rst_valid", bus.temp_valid, 0);
    chk("rst_fault", bus.fault, 0);
    reset = 1'b0;
    tick();

    // heater from edge 1: 21 at edge 5, 22 at edge 9
    bus.heater_on = 1'b1;
    tick();
    chk("heat_mode", bus.mode, 1);
    tick(3);
    chk("heat_pre", bus.current_temp, 20);
    tick();
    chk("heat_e5", bus.current_temp, 21);
    chk("heat_e5_v", bus.temp_valid, 1);
    tick();
    chk("heat_e6_v", bus.temp_valid, 0);
    tick(3);
    chk("heat_e9", bus.current_temp, 22);
    chk("heat_e9_v", bus.temp_valid, 1);

    // load on the step-due cycle
    tick(3);
    bus.temp_load  = 1'b1;
    bus.load_value = 8'd100;
    tick();
    bus.temp_load = 1'b0;
    chk("load_val", bus.current_temp, 100);
    chk("load_v", bus.temp_valid, 1);
    tick(3);
    chk("load_hold", bus.current_temp, 100);
    chk("load_hold_v", bus.temp_valid, 0);
    tick();
    chk("load_next", bus.current_temp, 101);

    // saturate at 255
    bus.temp_load  = 1'b1;
    bus.load_value = 8'd254;
    tick();
    bus.temp_load = 1'b0;
    chk("sat_load", bus.current_temp, 254);
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (bus.temp_valid) pulses++;
    end
    chk("sat_temp", bus.current_temp, 255);
    chk("sat_pulses", pulses, 1);

    // conflict then cooler only
    bus.cooler_on = 1'b1;
    tick();
    chk("conf_mode", bus.mode, 3);
    chk("conf_fault", bus.fault, 1);
    tick(2);
    chk("conf_temp", bus.current_temp, 255);
    chk("conf_v", bus.temp_valid, 0);
    bus.heater_on = 1'b0;
    tick();
    chk("cool_mode", bus.mode, 2);
    chk("cool_fault", bus.fault, 1);
    tick(5);
    chk("cool_pre", bus.current_temp, 255);
    tick();
    chk("cool_step", bus.current_temp, 254);
    chk("cool_step_v", bus.temp_valid, 1);
    chk("cool_fault2", bus.fault, 1);

    // reset two cycles into a heating period
    bus.cooler_on = 1'b0;
    bus.heater_on = 1'b1;
    tick();
    chk("r_heat_mode", bus.mode, 1);
    tick(2);
    reset = 1'b1;
    #1;
    chk("r_async_temp",  bus.current_temp, 20);
    chk("r_async_mode",  bus.mode, 0);
    chk("r_async_fault", bus.fault, 0);
    chk("r_async_v",     bus.temp_valid, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("r_post_mode", bus.mode, 1);
    tick(3);
    chk("r_post_pre", bus.current_temp, 20);
    tick();
    chk("r_post_step", bus.current_temp, 21);

    // idle with ambient below temperature
    bus.heater_on    = 1'b0;
    bus.ambient_temp = 8'd27;
    bus.temp_load    = 1'b1;
    bus.load_value   = 8'd30;
    tick();
    bus.temp_load = 1'b0;
    chk("idle_mode", bus.mode, 0);
    chk("idle_load", bus.current_temp, 30);
`ifdef AMBIENT_DRIFT_EN
    tick(4);
    chk("drift_29", bus.current_temp, 29);
    chk("drift_29_v", bus.temp_valid, 1);
    tick(4);
    chk("drift_28", bus.current_temp, 28);
    tick(4);
    chk("drift_27", bus.current_temp, 27);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.temp_valid) pulses++;
    end
    chk("drift_stable", bus.current_temp, 27);
    chk("drift_nopulse", pulses, 0);
`else
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.temp_valid) pulses++;
    end
    chk("idle_hold", bus.current_temp, 30);
    chk("idle_nopulse", pulses, 0);
`endif

    // load of the current value still pulses
    bus.temp_load  = 1'b1;
    bus.load_value = bus.current_temp;
    tick();
    bus.temp_load = 1'b0;
    chk("same_load_v", bus.temp_valid, 1);
    tick();
    chk("same_load_v0", bus.temp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
